// File: rtl/seg7_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_if
// Purpose  : Bundles the display-driver host controls (enable, load strobe,
//            BCD/decimal-point data, blanking mode) together with the board
//            pin outputs and status flags of seg7_scan_driver.
// Ports    : master modport - host side, drives the controls and reads pins/status
//            slave  modport - seg7_scan_driver side
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              seg;
  logic                    dp;
  logic [3:0]              led_bcd;
  logic [IDX_W-1:0]        digit_idx;
  logic                    pending;
  logic                    frame_tick;

  modport master (
    output enable, load, bcd_in, dp_in, blank_lz,
    input  anode, seg, dp, led_bcd, digit_idx, pending, frame_tick
  );

  modport slave (
    input  enable, load, bcd_in, dp_in, blank_lz,
    output anode, seg, dp, led_bcd, digit_idx, pending, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed N-digit seven-segment driver. Owns the slot
//            counter, anode scan, digit select and segment decode. Data is
//            double-buffered so a new value only appears at a frame boundary,
//            each slot opens with an all-dark guard interval against ghosting,
//            and leading zeros can be blanked.
// Ports    : clk, rst_n (synchronous, active-low)
//            bus.slave : enable, load, bcd_in, dp_in, blank_lz in;
//                        anode, seg, dp (active-low pins), led_bcd, digit_idx,
//                        pending, frame_tick out
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD   = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  // Active (displayed) and pending (waiting for frame boundary) buffers
  logic [4*NUM_DIGITS-1:0] r_act_bcd, r_pend_bcd;
  logic [NUM_DIGITS-1:0]   r_act_dp, r_pend_dp;
  logic                    r_pend_flag;
  // Registered pin drivers
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [3:0]              r_led_bcd;

  logic                    w_frame_tick;
  logic                    w_commit;
  logic                    w_in_guard;
  logic [NUM_DIGITS-1:0]   w_zero_above;
  logic [3:0]              w_sel_bcd;
  logic                    w_sel_dp;
  logic                    w_sel_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;  // non-BCD nibble shows a minus sign
    endcase
  endfunction

  assign w_frame_tick = bus.enable && (r_cnt == CNT_MAX) && (r_idx == IDX_MAX);
  // While disabled the display is dark anyway, so buffered data is committed
  // immediately rather than waiting for a boundary that will never come.
  assign w_commit     = w_frame_tick || !bus.enable;
  assign w_in_guard   = (r_cnt < GUARD);

  // w_zero_above[k] = every digit from k up to the MSD is zero. Digit 0 is
  // never blanked so a value of zero still shows a single "0".
  always_comb begin
    logic zero_run;
    zero_run     = 1'b1;
    w_zero_above = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run        = zero_run && (r_act_bcd[4*k +: 4] == 4'd0);
      w_zero_above[k] = zero_run;
    end
  end

  always_comb begin
    w_sel_bcd   = 4'd0;
    w_sel_dp    = 1'b0;
    w_sel_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_sel_bcd   = r_act_bcd[4*k +: 4];
        w_sel_dp    = r_act_dp[k];
        w_sel_blank = bus.blank_lz && w_zero_above[k];
      end
    end
  end

  // Slot counter and digit index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!bus.enable) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Double buffer: a load landing on a commit cycle bypasses the pending stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_act_bcd   <= '0;
      r_act_dp    <= '0;
      r_pend_bcd  <= '0;
      r_pend_dp   <= '0;
      r_pend_flag <= 1'b0;
    end else if (bus.load && w_commit) begin
      r_act_bcd   <= bus.bcd_in;
      r_act_dp    <= bus.dp_in;
      r_pend_flag <= 1'b0;
    end else if (bus.load) begin
      r_pend_bcd  <= bus.bcd_in;
      r_pend_dp   <= bus.dp_in;
      r_pend_flag <= 1'b1;
    end else if (r_pend_flag && w_commit) begin
      r_act_bcd   <= r_pend_bcd;
      r_act_dp    <= r_pend_dp;
      r_pend_flag <= 1'b0;
    end
  end

  // Pin drivers, registered one cycle behind the scan state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_anode   <= '1;
      r_seg     <= 7'h7F;
      r_dp      <= 1'b1;
      r_led_bcd <= 4'd0;
    end else begin
      r_led_bcd <= bus.enable ? w_sel_bcd : 4'd0;
      if (!bus.enable || w_in_guard) begin
        r_anode <= '1;
        r_seg   <= 7'h7F;
        r_dp    <= 1'b1;
      end else begin
        r_anode <= ~(NUM_DIGITS'(1) << r_idx);
        r_seg   <= w_sel_blank ? 7'h7F : seg_decode(w_sel_bcd);
        r_dp    <= ~w_sel_dp;
      end
    end
  end

  assign bus.anode      = r_anode;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.led_bcd    = r_led_bcd;
  assign bus.digit_idx  = r_idx;
  assign bus.pending    = r_pend_flag;
  assign bus.frame_tick = w_frame_tick;
endmodule
`default_nettype wire
